// File: rtl/ram_pkg.sv
// Shared types and default widths for the dual-port clearable RAM.
// The enum encodes the clear sequencer's two states.
package ram_pkg;

  localparam int unsigned RAM_DATA_W = 8;
  localparam int unsigned RAM_ADDR_W = 8;

  typedef enum logic [0:0] {
    RAM_READY,
    RAM_CLEAR
  } ram_state_e;

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: walks a pointer across the whole array, writing zeros.
// It reports busy for exactly DEPTH cycles per sweep.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_W         = RAM_ADDR_W,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  output logic              zero_we,
  output logic [ADDR_W-1:0] zero_addr
);

  ram_state_e        state;
  logic [ADDR_W-1:0] ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR_ON_RESET ? RAM_CLEAR : RAM_READY;
      ptr   <= '0;
    end else begin
      unique case (state)
        RAM_READY: begin
          if (clr) begin
            state <= RAM_CLEAR;
          end
          ptr <= '0;
        end
        RAM_CLEAR: begin
          // clr is ignored mid-sweep; the sweep always runs to the end.
          if (&ptr) begin
            state <= RAM_READY;
            ptr   <= '0;
          end else begin
            ptr <= ptr + ADDR_W'(1);
          end
        end
        default: begin
          state <= RAM_READY;
          ptr   <= '0;
        end
      endcase
    end
  end

  assign busy      = (state == RAM_CLEAR);
  // Reset itself must never modify the array.
  assign zero_we   = busy & ~rst;
  assign zero_addr = ptr;

endmodule

// File: rtl/ram_dp_clr.sv
// Dual-port RAM: port A read/write, port B read-only, both with registered
// reads and valid strobes; a built-in sweep zeroes the array on demand.
module ram_dp_clr
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W         = RAM_DATA_W,
  parameter int unsigned ADDR_W         = RAM_ADDR_W,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  output logic              drop_err,
  input  logic              a_cs,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_cs,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              zero_we;
  logic [ADDR_W-1:0] zero_addr;
  logic              blocked;
  logic              a_wr;
  logic              a_rd;
  logic              b_rd;
  logic              b_fwd;
  logic              drop;

  ram_clear_seq #(
    .ADDR_W        (ADDR_W),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .busy     (busy),
    .zero_we  (zero_we),
    .zero_addr(zero_addr)
  );

  // A clr accepted in READY takes priority over any access in that cycle.
  assign blocked = busy | clr | rst;
  assign a_wr    = a_cs & a_we & ~blocked;
  assign a_rd    = a_cs & ~a_we & ~blocked;
  assign b_rd    = b_cs & ~blocked;
  assign b_fwd   = a_wr & (a_addr == b_addr);
  assign drop    = ((a_cs | b_cs) & (busy | clr)) | (clr & busy);

  always_ff @(posedge clk) begin
    if (zero_we) begin
      mem[zero_addr] <= '0;
    end else if (a_wr) begin
      mem[a_addr] <= a_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_rdata  <= '0;
      a_rvalid <= 1'b0;
      b_rdata  <= '0;
      b_rvalid <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      a_rvalid <= a_rd;
      b_rvalid <= b_rd;
      if (a_rd) begin
        a_rdata <= mem[a_addr];
      end
      if (b_rd) begin
        b_rdata <= b_fwd ? a_wdata : mem[b_addr];
      end
      if (drop) begin
        drop_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram_dp_clr.sv
// Scoreboard bench for ram_dp_clr with a 16-word array: a reference model
// predicts each cycle's outputs, which are queued and checked after the edge.
module tb_ram_dp_clr;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          busy;
  logic          drop_err;
  logic          a_cs = 1'b0;
  logic          a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic [DW-1:0] a_rdata;
  logic          a_rvalid;
  logic          b_cs = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_rdata;
  logic          b_rvalid;

  ram_dp_clr #(
    .DATA_W        (DW),
    .ADDR_W        (AW),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .busy    (busy),
    .drop_err(drop_err),
    .a_cs    (a_cs),
    .a_we    (a_we),
    .a_addr  (a_addr),
    .a_wdata (a_wdata),
    .a_rdata (a_rdata),
    .a_rvalid(a_rvalid),
    .b_cs    (b_cs),
    .b_addr  (b_addr),
    .b_rdata (b_rdata),
    .b_rvalid(b_rvalid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          av;
    logic [DW-1:0] ad;
    logic          bv;
    logic [DW-1:0] bd;
    logic          drop;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [DW-1:0] m_mem [DEPTH];
  int            m_cnt = 0;
  logic          m_drop = 1'b0;
  logic [DW-1:0] m_ard = '0;
  logic [DW-1:0] m_brd = '0;
  logic          last_busy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_eq("a_rvalid", {31'd0, a_rvalid}, {31'd0, e.av});
      check_eq("a_rdata", {24'd0, a_rdata}, {24'd0, e.ad});
      check_eq("b_rvalid", {31'd0, b_rvalid}, {31'd0, e.bv});
      check_eq("b_rdata", {24'd0, b_rdata}, {24'd0, e.bd});
      check_eq("drop_err", {31'd0, drop_err}, {31'd0, e.drop});
    end
  end

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1; clr = 1'b0; a_cs = 1'b0; a_we = 1'b0; b_cs = 1'b0;
      m_cnt  = DEPTH;
      m_drop = 1'b0;
      m_ard  = '0;
      m_brd  = '0;
      for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
      sb.push_back('{av: 1'b0, ad: '0, bv: 1'b0, bd: '0, drop: 1'b0});
    end
  endtask

  task automatic cyc(input logic c, input logic acs, input logic awe, input logic [AW-1:0] aa,
                     input logic [DW-1:0] awd, input logic bcs, input logic [AW-1:0] ba);
    logic bsy, blk, ard, awr, brd;
    @(negedge clk);
    bsy = (m_cnt != 0);
    last_busy = busy;
    check_eq("busy", {31'd0, busy}, {31'd0, bsy});
    rst = 1'b0; clr = c; a_cs = acs; a_we = awe; a_addr = aa; a_wdata = awd;
    b_cs = bcs; b_addr = ba;
    blk = bsy | c;
    if ((c & bsy) | ((acs | bcs) & blk)) m_drop = 1'b1;
    ard = acs & ~awe & ~blk;
    awr = acs & awe & ~blk;
    brd = bcs & ~blk;
    if (ard) m_ard = m_mem[aa];
    if (brd) m_brd = (awr && aa == ba) ? awd : m_mem[ba];
    sb.push_back('{av: ard, ad: m_ard, bv: brd, bd: m_brd, drop: m_drop});
    if (awr) m_mem[aa] = awd;
    if (bsy) m_cnt--;
    else if (c) begin
      m_cnt = DEPTH;
      for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
    end
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  // Run idle cycles while busy, returning how many busy cycles were seen.
  task automatic count_busy(output int cnt);
    cnt = 0;
    for (int i = 0; i < 4 * DEPTH; i++) begin
      idle();
      if (!last_busy) break;
      cnt++;
    end
  endtask

  task automatic read_all_a();
    for (int k = 0; k < DEPTH; k++) cyc(1'b0, 1'b1, 1'b0, AW'(k), '0, 1'b0, '0);
  endtask

  initial begin
    int cnt;

    // Reset release and initial sweep
    do_reset(2);
    count_busy(cnt);
    check_eq("busy_len_reset", cnt, DEPTH);
    read_all_a();

    // Write then dual read of the same word
    cyc(1'b0, 1'b1, 1'b1, 4'd3, 8'hA5, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b0, 4'd3, '0, 1'b1, 4'd3);
    idle();

    // Write-first forwarding to port B
    cyc(1'b0, 1'b1, 1'b1, 4'd7, 8'h3C, 1'b1, 4'd7);
    cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 4'd2);

    // Back-to-back reads with alternating addresses
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 1'b0, AW'(k * 2 + 3), '0, 1'b1, AW'(7 - k));

    // Fill with 0xFF, then clr together with a write
    for (int k = 0; k < DEPTH; k++) cyc(1'b0, 1'b1, 1'b1, AW'(k), 8'hFF, 1'b0, '0);
    cyc(1'b1, 1'b1, 1'b1, 4'd0, 8'h11, 1'b0, '0);
    count_busy(cnt);
    check_eq("busy_len_clr", cnt, DEPTH);
    check_eq("drop_after_clr", {31'd0, drop_err}, 32'd1);
    read_all_a();

    // Access and repeated clr while busy
    do_reset(1);
    count_busy(cnt);
    cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    cnt = 0;
    for (int i = 0; i < 4 * DEPTH; i++) begin
      cyc(i == 6, 1'b0, 1'b0, '0, '0, i == 3, 4'd5);
      if (!last_busy) break;
      cnt++;
    end
    check_eq("busy_len_reclr", cnt, DEPTH);

    // Reset in the middle of a sweep
    do_reset(1);
    for (int i = 0; i < 9; i++) idle();
    do_reset(1);
    count_busy(cnt);
    check_eq("busy_len_rst_mid", cnt, DEPTH);
    check_eq("drop_after_rst", {31'd0, drop_err}, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 4'd9, '0, 1'b1, 4'd12);

    idle();
    idle();
    @(posedge clk);
    #2;
    check_eq("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
